uart_wb_master: RTL and testbench
=================================

# uart_wb_master

Byte-stream-to-Wishbone bridge: consumes bytes from a UART receiver, decodes a fixed command frame and acts as Wishbone initiator on the system bus, then returns status/read data through a UART transmitter. It is the host-side debug/load path into the same bus the memory-mapped UART peripheral hangs off, and connects to the byte-level ports of the existing `uart` core (rx_data/rx_done, tx_data/tx_start/tx_busy).

## Interface
- TIMEOUT, 1024: max cycles a bus cycle waits for wb_ack_i before abort (>= 2).
- CMD_WR, 8'h57: command byte for a 32-bit write.
- CMD_RD, 8'h52: command byte for a 32-bit read.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high; clock clk.
- rx_data  in  8  received byte, valid while rx_done=1.
- rx_done  in  1  one-cycle pulse per received byte.
- tx_data  out  8  byte to transmit, held stable from tx_start until tx_busy falls.
- tx_start  out  1  one-cycle pulse requesting transmission.
- tx_busy  in  1  transmitter busy.
- wb_adr_o  out  32  bus address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  4  byte selects, always 4'hF during a cycle.
- wb_stb_o, wb_cyc_o  out  1  strobe/cycle, always driven identically.
- wb_ack_i  in  1  bus acknowledge.
- busy  out  1  high in every state except IDLE.

## Operation
- Frame: command byte, 4 address bytes MSB first, then for CMD_WR 4 data bytes MSB first. Byte counter 0..3 per field.
- States: IDLE -> ADDR -> (DATA if write) -> BUS -> RESP -> IDLE.
- IDLE: rx_done with CMD_WR/CMD_RD latches direction, goes ADDR; any other byte is dropped, stay IDLE.
- ADDR/DATA: each rx_done shifts byte into low end of the address/data register (reg <= {reg[23:0], rx_data}); after 4th byte advance.
- BUS: cyc/stb/sel asserted, we=write; wait counter counts from 0. wb_ack_i=1 ends cycle (read data latched same edge). Counter reaching TIMEOUT-1 without ack ends cycle with error flag.
- RESP bytes: write OK -> 8'h4B; read OK -> 4 bytes of latched read data MSB first; any timeout -> single 8'hEE.
- Transmit handshake: tx_start pulsed only when tx_busy=0 and no tx_start in the previous cycle; next byte only after tx_busy observed low again following at least one idle cycle after the previous pulse. tx_data changes only at a tx_start pulse.
- rx_done during BUS or RESP: byte dropped (no queuing).
- Reset: all outputs 0, state IDLE, registers cleared. Reset during BUS drops cyc/stb immediately (async); no response sent.

## Timing
- Final frame byte rx_done at cycle N -> wb_cyc_o/wb_stb_o high at N+1.
- wb_ack_i sampled high at edge M -> cyc/stb/we low from M+1; first tx_start at M+1 if tx_busy=0.
- Zero-wait slave (ack registered one cycle after stb): cycle lasts exactly 2 clocks.
- Timeout: cyc/stb high for exactly TIMEOUT cycles, low the next.
- Ack arriving on the same edge as timeout expiry counts as success.
- Ack outside BUS is ignored.
- Return to IDLE the cycle after the last response byte's tx_start; busy falls then.

## Test plan
- Write: bytes 57 10 00 00 04 DE AD BE EF -> one cycle adr=0x10000004, dat=0xDEADBEEF, we=1, sel=F; response byte 0x4B.
- Read: bytes 52 00 00 00 08, slave returns 0x12345678 -> we=0 cycle at adr=0x00000008; tx bytes 12 34 56 78 in order, each tx_start only while tx_busy=0.
- Timeout: read with no ack, TIMEOUT=16 -> cyc high exactly 16 cycles, single response 0xEE, busy low afterward.
- Garbage/drop: bytes 00 FF then valid read; plus extra byte injected during BUS -> no spurious cycles, extra byte ignored, correct read response.
- Reset mid-BUS: assert rst while cyc=1 -> cyc/stb/tx_start 0 immediately; next valid write frame completes normally.
- Timing: zero-wait slave -> cyc asserted cycle after last rx_done, deasserted cycle after ack.

Source files
------------

// File: rtl/uart_wb_master_if.sv
// Wishbone classic initiator/target signal bundle used by the UART debug bridge.
// Signal names keep the initiator-side _o/_i suffixes so both ends read the same.
interface uart_wb_master_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/uart_wb_master.sv
// UART byte stream to Wishbone bridge: decodes cmd/addr/data frames, runs one
// bus cycle with ack timeout, and returns status or read data as UART bytes.
module uart_wb_master #(
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [7:0]  CMD_WR  = 8'h57,
  parameter logic [7:0]  CMD_RD  = 8'h52
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  output logic             busy,
  uart_wb_master_if.master wb
);

  localparam int unsigned     WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [7:0]      RSP_OK    = 8'h4B;
  localparam logic [7:0]      RSP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [31:0]         adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [31:0]         rdat_q, rdat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [2:0]          sent_q, sent_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                hold_q, hold_d;

  logic                can_tx;
  logic [2:0]          resp_last;

  // hold_q covers the idle cycle after a pulse so tx_busy has time to rise
  // before it is trusted again.
  assign can_tx    = !tx_start_q && !hold_q && !tx_busy;
  assign resp_last = (err_q || we_q) ? 3'd1 : 3'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      rdat_q     <= '0;
      wait_q     <= '0;
      sent_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rdat_q     <= rdat_d;
      wait_q     <= wait_d;
      sent_q     <= sent_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    err_d      = err_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rdat_d     = rdat_q;
    wait_d     = wait_q;
    sent_d     = sent_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    hold_d     = tx_start_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_done && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
          we_d    = (rx_data == CMD_WR);
          err_d   = 1'b0;
          cnt_d   = 2'd0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (rx_done) begin
          adr_d = {adr_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wait_d  = '0;
            state_d = we_q ? S_DATA : S_BUS;
          end
        end
      end

      S_DATA: begin
        if (rx_done) begin
          dat_d = {dat_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wait_d  = '0;
            state_d = S_BUS;
          end
        end
      end

      S_BUS: begin
        // Ack wins over expiry on the same edge; the first response byte is
        // launched straight from here so it leaves the cycle after the ack.
        if (wb.wb_ack_i) begin
          err_d   = 1'b0;
          sent_d  = 3'd0;
          rdat_d  = wb.wb_dat_i;
          state_d = S_RESP;
          if (can_tx) begin
            tx_start_d = 1'b1;
            sent_d     = 3'd1;
            if (we_q) begin
              tx_data_d = RSP_OK;
            end else begin
              tx_data_d = wb.wb_dat_i[31:24];
              rdat_d    = {wb.wb_dat_i[23:0], 8'h00};
            end
          end
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          sent_d  = 3'd0;
          state_d = S_RESP;
          if (can_tx) begin
            tx_start_d = 1'b1;
            tx_data_d  = RSP_ERR;
            sent_d     = 3'd1;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_RESP: begin
        // sent_q reaches resp_last in the cycle of the final pulse.
        if (sent_q == resp_last) begin
          state_d = S_IDLE;
        end else if (can_tx) begin
          tx_start_d = 1'b1;
          sent_d     = sent_q + 3'd1;
          if (err_q) begin
            tx_data_d = RSP_ERR;
          end else if (we_q) begin
            tx_data_d = RSP_OK;
          end else begin
            tx_data_d = rdat_q[31:24];
            rdat_d    = {rdat_q[23:0], 8'h00};
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign wb.wb_cyc_o = (state_q == S_BUS);
  assign wb.wb_stb_o = (state_q == S_BUS);
  assign wb.wb_we_o  = (state_q == S_BUS) && we_q;
  assign wb.wb_sel_o = (state_q == S_BUS) ? 4'hF : 4'h0;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master: frames in over the byte port, a small
// Wishbone target and UART transmitter model, hand-computed expectations.
module tb_uart_wb_master;
  localparam int TO    = 16;
  localparam int TXLEN = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;

  uart_wb_master_if wb();

  uart_wb_master #(.TIMEOUT(TO), .CMD_WR(8'h57), .CMD_RD(8'h52)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .busy     (busy),
    .wb       (wb)
  );

  always #5 clk = ~clk;

  // Wishbone target with programmable ack latency
  logic        ack_r = 1'b0;
  logic [31:0] rd_val = 32'h0;
  logic        slave_en = 1'b0;
  int          ack_delay = 0;
  int          wcnt = 0;
  assign wb.wb_ack_i = ack_r;
  assign wb.wb_dat_i = rd_val;

  always @(posedge clk) begin
    if (wb.wb_cyc_o && wb.wb_stb_o && !ack_r && slave_en) begin
      if (wcnt == ack_delay) begin
        ack_r <= 1'b1;
        wcnt  <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      ack_r <= 1'b0;
      if (!wb.wb_cyc_o) wcnt <= 0;
    end
  end

  // Transmitter model: busy for TXLEN cycles after each pulse
  int txb_cnt = 0;
  assign tx_busy = (txb_cnt != 0);
  always @(posedge clk) begin
    if (tx_start) txb_cnt <= TXLEN;
    else if (txb_cnt != 0) txb_cnt <= txb_cnt - 1;
  end

  // Monitor
  int          edge_n = 0;
  int          last_rx_edge = 0, first_cyc_edge = 0, fall_edge = 0, ack_edge = 0, tx_edge = 0;
  int          ncyc = 0, cyc_hi = 0, viol = 0;
  logic        cyc_prev = 1'b0, txs_prev = 1'b0;
  logic [7:0]  txd_prev = 8'h00;
  logic [31:0] cap_adr = 0, cap_dat = 0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_sel = 4'h0;
  logic [7:0]  tx_log[$];
  logic        hs_bad;

  assign hs_bad = (wb.wb_stb_o != wb.wb_cyc_o) ||
                  (wb.wb_cyc_o && wb.wb_sel_o != 4'hF) ||
                  (tx_start && tx_busy) ||
                  (tx_start && txs_prev) ||
                  (!rst && !tx_start && tx_data != txd_prev);

  always @(posedge clk) begin
    edge_n   <= edge_n + 1;
    cyc_prev <= wb.wb_cyc_o;
    txs_prev <= tx_start;
    txd_prev <= tx_data;
    if (rx_done) last_rx_edge <= edge_n;
    if (wb.wb_cyc_o) begin
      cyc_hi <= cyc_hi + 1;
      if (!cyc_prev) begin
        ncyc           <= ncyc + 1;
        first_cyc_edge <= edge_n;
      end
    end else if (cyc_prev) begin
      fall_edge <= edge_n;
    end
    if (wb.wb_cyc_o && wb.wb_ack_i) begin
      cap_adr  <= wb.wb_adr_o;
      cap_dat  <= wb.wb_dat_o;
      cap_we   <= wb.wb_we_o;
      cap_sel  <= wb.wb_sel_o;
      ack_edge <= edge_n;
    end
    if (hs_bad) viol <= viol + 1;
    if (tx_start) begin
      tx_log.push_back(tx_data);
      tx_edge <= edge_n;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] a;
    logic [31:0] d;
    a = adr;
    d = dat;
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8]);
    if (cmd == 8'h57)
      for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle"}, 32'(busy), 32'h0);
    repeat (10) @(negedge clk);
  endtask

  int b_cyc, b_hi, b_tx, b_v;

  task automatic mark();
    b_cyc = ncyc;
    b_hi  = cyc_hi;
    b_tx  = tx_log.size();
    b_v   = viol;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_cyc", 32'(wb.wb_cyc_o), 32'h0);
    check_eq("rst_stb", 32'(wb.wb_stb_o), 32'h0);
    check_eq("rst_txs", 32'(tx_start), 32'h0);
    check_eq("rst_adr", wb.wb_adr_o, 32'h0);
    check_eq("rst_sel", 32'(wb.wb_sel_o), 32'h0);

    // Write with zero-wait target, plus cycle timing
    slave_en = 1'b1; ack_delay = 0; mark();
    send_frame(8'h57, 32'h10000004, 32'hDEADBEEF);
    wait_idle("wr");
    $display("txn write adr=%h dat=%h we=%0d resp=%h", cap_adr, cap_dat, cap_we, tx_log[tx_log.size()-1]);
    check_eq("wr_ncyc", 32'(ncyc - b_cyc), 32'd1);
    check_eq("wr_adr", cap_adr, 32'h10000004);
    check_eq("wr_dat", cap_dat, 32'hDEADBEEF);
    check_eq("wr_we", 32'(cap_we), 32'h1);
    check_eq("wr_sel", 32'(cap_sel), 32'hF);
    check_eq("wr_cyc_len", 32'(cyc_hi - b_hi), 32'd2);
    check_eq("wr_cyc_start", 32'(first_cyc_edge - last_rx_edge), 32'd1);
    check_eq("wr_cyc_fall", 32'(fall_edge - ack_edge), 32'd1);
    check_eq("wr_tx_lat", 32'(tx_edge - ack_edge), 32'd1);
    check_eq("wr_tx_cnt", 32'(tx_log.size() - b_tx), 32'd1);
    check_eq("wr_tx_b0", 32'(tx_log[b_tx]), 32'h4B);
    check_eq("wr_viol", 32'(viol - b_v), 32'd0);

    // Read, four data bytes back MSB first
    rd_val = 32'h12345678; ack_delay = 1; mark();
    send_frame(8'h52, 32'h00000008, 32'h0);
    wait_idle("rd");
    $display("txn read adr=%h we=%0d bytes=%0d", cap_adr, cap_we, tx_log.size() - b_tx);
    check_eq("rd_ncyc", 32'(ncyc - b_cyc), 32'd1);
    check_eq("rd_adr", cap_adr, 32'h00000008);
    check_eq("rd_we", 32'(cap_we), 32'h0);
    check_eq("rd_tx_cnt", 32'(tx_log.size() - b_tx), 32'd4);
    check_eq("rd_tx_b0", 32'(tx_log[b_tx]), 32'h12);
    check_eq("rd_tx_b1", 32'(tx_log[b_tx+1]), 32'h34);
    check_eq("rd_tx_b2", 32'(tx_log[b_tx+2]), 32'h56);
    check_eq("rd_tx_b3", 32'(tx_log[b_tx+3]), 32'h78);
    check_eq("rd_viol", 32'(viol - b_v), 32'd0);

    // Timeout: no ack
    slave_en = 1'b0; mark();
    send_frame(8'h52, 32'h00000020, 32'h0);
    wait_idle("to");
    $display("txn timeout adr=00000020 cyc_len=%0d resp=%h", cyc_hi - b_hi, tx_log[tx_log.size()-1]);
    check_eq("to_ncyc", 32'(ncyc - b_cyc), 32'd1);
    check_eq("to_cyc_len", 32'(cyc_hi - b_hi), 32'(TO));
    check_eq("to_tx_cnt", 32'(tx_log.size() - b_tx), 32'd1);
    check_eq("to_tx_b0", 32'(tx_log[b_tx]), 32'hEE);
    check_eq("to_busy", 32'(busy), 32'h0);
    check_eq("to_viol", 32'(viol - b_v), 32'd0);

    // Garbage bytes, then a read with a byte injected during the bus cycle
    mark();
    send_byte(8'h00);
    send_byte(8'hFF);
    check_eq("gb_busy", 32'(busy), 32'h0);
    check_eq("gb_nocyc", 32'(ncyc - b_cyc), 32'd0);
    slave_en = 1'b1; ack_delay = 8; rd_val = 32'hCAFEF00D;
    send_frame(8'h52, 32'h00000100, 32'h0);
    check_eq("gb_inbus", 32'(wb.wb_cyc_o), 32'h1);
    send_byte(8'h57);
    wait_idle("gb");
    repeat (20) @(negedge clk);
    $display("txn drop+read adr=%h bytes=%0d", cap_adr, tx_log.size() - b_tx);
    check_eq("gb_ncyc", 32'(ncyc - b_cyc), 32'd1);
    check_eq("gb_adr", cap_adr, 32'h00000100);
    check_eq("gb_tx_cnt", 32'(tx_log.size() - b_tx), 32'd4);
    check_eq("gb_tx_b0", 32'(tx_log[b_tx]), 32'hCA);
    check_eq("gb_tx_b3", 32'(tx_log[b_tx+3]), 32'h0D);
    check_eq("gb_after_busy", 32'(busy), 32'h0);
    check_eq("gb_viol", 32'(viol - b_v), 32'd0);

    // Reset in the middle of a bus cycle
    slave_en = 1'b0; mark();
    send_frame(8'h52, 32'h00000040, 32'h0);
    check_eq("rb_inbus", 32'(wb.wb_cyc_o), 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rb_cyc", 32'(wb.wb_cyc_o), 32'h0);
    check_eq("rb_stb", 32'(wb.wb_stb_o), 32'h0);
    check_eq("rb_txs", 32'(tx_start), 32'h0);
    check_eq("rb_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rb_no_resp", 32'(tx_log.size() - b_tx), 32'd0);
    $display("txn reset-mid-bus adr=00000040 responses=%0d", tx_log.size() - b_tx);
    slave_en = 1'b1; ack_delay = 0; mark();
    send_frame(8'h57, 32'hAABBCCDD, 32'h01020304);
    wait_idle("rw");
    $display("txn write adr=%h dat=%h resp=%h", cap_adr, cap_dat, tx_log[tx_log.size()-1]);
    check_eq("rw_ncyc", 32'(ncyc - b_cyc), 32'd1);
    check_eq("rw_adr", cap_adr, 32'hAABBCCDD);
    check_eq("rw_dat", cap_dat, 32'h01020304);
    check_eq("rw_tx_cnt", 32'(tx_log.size() - b_tx), 32'd1);
    check_eq("rw_tx_b0", 32'(tx_log[b_tx]), 32'h4B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
